// File: rtl/hilo_pkg.sv
// Shared opcode encoding and accumulator limits for the HI/LO accumulator.
package hilo_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_MULT = 3'b001,
        OP_MADD = 3'b010,
        OP_MSUB = 3'b011,
        OP_MTHI = 3'b100,
        OP_MTLO = 3'b101,
        OP_CLR  = 3'b110,
        OP_RSVD = 3'b111
    } op_e;

    localparam int HILO_W = 32;
    localparam int ACC_W  = 2 * HILO_W;

    // Signed extremes of the {HI,LO} accumulator at the default width.
    localparam logic [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

endpackage

// File: rtl/hilo_accumulator_if.sv
// Operation/result bundle between the multiplier front end and the HI/LO accumulator.
interface hilo_accumulator_if #(
    parameter int W = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       in_op;
    logic [2*W-1:0]   in_prod;
    logic [W-1:0]     in_wdata;
    logic             flush;
    logic [W-1:0]     hi;
    logic [W-1:0]     lo;
    logic             busy;
    logic             ovf;

    modport master (
        output in_valid, in_op, in_prod, in_wdata, flush,
        input  in_ready, hi, lo, busy, ovf
    );

    modport slave (
        input  in_valid, in_op, in_prod, in_wdata, flush,
        output in_ready, hi, lo, busy, ovf
    );
endinterface

// File: rtl/hilo_addsub_sat.sv
// Combinational signed acc +/- prod with overflow detect and optional saturation.
module hilo_addsub_sat #(
    parameter int PW     = 64,
    parameter bit SAT_EN = 1'b0
) (
    input  logic [PW-1:0] acc,
    input  logic [PW-1:0] prod,
    input  logic          sub,
    output logic [PW-1:0] result,
    output logic          ovf
);
    localparam logic [PW-1:0] SAT_MAX = {1'b0, {(PW-1){1'b1}}};
    localparam logic [PW-1:0] SAT_MIN = {1'b1, {(PW-1){1'b0}}};

    logic [PW-1:0] operand;
    logic [PW-1:0] raw;

    // Subtract as acc + ~prod + 1; judging overflow on the inverted operand keeps
    // prod = most-negative correct, where negating prod itself would wrap.
    always_comb begin
        operand = sub ? ~prod : prod;
        raw     = acc + operand + {{(PW-1){1'b0}}, sub};
        ovf     = (acc[PW-1] == operand[PW-1]) && (raw[PW-1] != acc[PW-1]);
        result  = raw;
        if (SAT_EN && ovf) begin
            result = acc[PW-1] ? SAT_MIN : SAT_MAX;
        end
    end

endmodule

// File: rtl/hilo_accumulator.sv
// Two-stage HI/LO accumulator: stage 1 captures the op, stage 2 commits to HI/LO.
module hilo_accumulator
    import hilo_pkg::*;
#(
    parameter bit SAT_EN = 1'b0,
    parameter int W      = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    hilo_accumulator_if.slave bus
);
    localparam int PW = 2 * W;

    logic          s1_valid;
    op_e           s1_op;
    logic [PW-1:0] s1_prod;
    logic [W-1:0]  s1_wdata;

    logic [W-1:0]  hi_q;
    logic [W-1:0]  lo_q;
    logic          ovf_q;

    logic          accept;
    logic          commit;
    logic [PW-1:0] as_result;
    logic          as_ovf;

    assign accept = bus.in_valid && !bus.flush;
    assign commit = s1_valid && !bus.flush;

    hilo_addsub_sat #(
        .PW     (PW),
        .SAT_EN (SAT_EN)
    ) u_addsub (
        .acc    ({hi_q, lo_q}),
        .prod   (s1_prod),
        .sub    (s1_op == OP_MSUB),
        .result (as_result),
        .ovf    (as_ovf)
    );

    // Stage 1: capture the offered op; a flush empties the stage without accepting.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_op    <= OP_NOP;
            s1_prod  <= '0;
            s1_wdata <= '0;
        end else begin
            s1_valid <= accept;
            if (accept) begin
                s1_op    <= op_e'(bus.in_op);
                s1_prod  <= bus.in_prod;
                s1_wdata <= bus.in_wdata;
            end
        end
    end

    // Stage 2: commit the stage-1 op into HI/LO and the sticky overflow flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_q  <= '0;
            lo_q  <= '0;
            ovf_q <= 1'b0;
        end else if (commit) begin
            case (s1_op)
                OP_MULT: {hi_q, lo_q} <= s1_prod;
                OP_MADD,
                OP_MSUB: begin
                    {hi_q, lo_q} <= as_result;
                    if (as_ovf) begin
                        ovf_q <= 1'b1;
                    end
                end
                OP_MTHI: hi_q <= s1_wdata;
                OP_MTLO: lo_q <= s1_wdata;
                OP_CLR: begin
                    hi_q  <= '0;
                    lo_q  <= '0;
                    ovf_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready = !bus.flush;
    assign bus.hi       = hi_q;
    assign bus.lo       = lo_q;
    assign bus.busy     = s1_valid;
    assign bus.ovf      = ovf_q;

endmodule

// File: doc/hilo_accumulator.md
Name: hilo_accumulator

Overview:
- Downstream consumer of the combinational signed 32x32->64 multiplier in the ALU datapath.
- Registers each 64-bit signed product with its opcode, then commits it into architectural HI/LO registers.
- Commit modes: load, accumulate, or subtract, with optional saturation.
- Also supports direct HI/LO writes and clear; exposes HI, LO and a busy flag to the register-read stage.

Parameters:
- SAT_EN, 0, 1 = saturate MADD/MSUB results on signed 64-bit overflow; 0 = wrap.
- W, 32, half-width of HI/LO; product width is 2*W.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operation offered this cycle.
- in_ready  out  1  block can accept an operation.
- in_op  in  3  opcode (see Behaviour).
- in_prod  in  2W  signed product from the multiplier.
- in_wdata  in  W  data for MTHI/MTLO.
- flush  in  1  discard the uncommitted operation.
- hi  out  W  HI register.
- lo  out  W  LO register.
- busy  out  1  an operation is pending commit; HI/LO are stale.
- ovf  out  1  sticky signed-overflow flag.

Behaviour:
- Reset (async, rst_n=0): hi=0, lo=0, ovf=0, busy=0, stage-1 valid=0. Effect is immediate, not clock-gated. Reset in mid-operation drops the pending op with no commit.
- Opcodes: 000 NOP; 001 MULT (HI:LO=P); 010 MADD (HI:LO+=P); 011 MSUB (HI:LO-=P); 100 MTHI (HI=wdata); 101 MTLO (LO=wdata); 110 CLR (HI=LO=0, ovf=0); 111 reserved, treated as NOP.
- in_ready = !flush. No other back-pressure: the commit stage always completes in one cycle.
- Accept occurs at a rising edge with in_valid & in_ready.
  - in_op, in_prod and in_wdata are latched into stage 1; s1_valid is set.
  - NOP and 111 are latched but commit nothing.
- Commit: at the next edge, if s1_valid, stage 2 updates HI/LO/ovf from s1 contents and the current HI/LO.
  - Total latency: accept at edge N, new HI/LO visible after edge N+1.
- busy = s1_valid (registered).
- Back-to-back ops: accept every cycle is legal; stage 2 always reads the freshly committed HI/LO, so no hazard and no bypass are needed.
- Accept and commit on the same edge: the older op commits and the new op loads into stage 1.
- flush=1: at the edge, s1_valid clears without commit; no accept that cycle (in_ready=0). Flush with s1 empty has no effect.
- MADD/MSUB arithmetic: 2W-bit two's complement; the accumulator {HI,LO} is signed.
  - Overflow when operand signs match and the result sign differs from them. For MSUB, compare signs of acc and -P; a P of -2^63 is handled by using the carry-based detection of the subtract.
  - On overflow, ovf is set. If SAT_EN=1, the result is 0x7FFF_FFFF_FFFF_FFFF for positive overflow and 0x8000_0000_0000_0000 for negative; otherwise the wrapped value.
  - MULT never sets ovf.
- ovf is sticky. It is cleared only by CLR or reset. CLR committing while overflow is detected cannot occur, since CLR has no add.
- MTHI/MTLO leave the other half and ovf unchanged.

Decomposition:
- Package hilo_pkg holds:
  - the op enum (OP_NOP, OP_MULT, OP_MADD, OP_MSUB, OP_MTHI, OP_MTLO, OP_CLR);
  - localparams ACC_MAX and ACC_MIN, parameterised by 2W.
- One sub-module: hilo_addsub_sat. It is purely combinational: signed acc ± P, overflow detect, optional saturate.
- The top level owns the stage-1 register, control and HI/LO/ovf registers.

Test Plan:
- Reset: drop rst_n mid-op after MULT with P=0x0000_0001_0000_0002 -> hi=0, lo=0, busy=0, ovf=0 immediately; no commit after release.
- MULT latency: accept MULT P=0xFFFF_FFFF_FFFF_FFFA (-6) at edge N -> busy=1 after N; hi=0xFFFF_FFFF, lo=0xFFFF_FFFA after N+1.
- Back-to-back accumulation: MULT P=5, then MADD P=7, then MSUB P=20 on consecutive cycles -> final {hi,lo}=-8 (0xFFFF_FFFF_FFFF_FFF8), ovf=0.
- Overflow: MTHI 0x7FFF_FFFF, MTLO 0xFFFF_FFFF, MADD P=1.
  - SAT_EN=0 -> {hi,lo}=0x8000_0000_0000_0000, ovf=1.
  - SAT_EN=1 -> 0x7FFF_FFFF_FFFF_FFFF, ovf=1.
  - Then CLR -> all zero, ovf=0.
- Flush: accept MULT P=9 (HI:LO previously 3), assert flush the next cycle -> in_ready=0 that cycle, HI:LO stays 3, busy=0.
- MTHI/MTLO/reserved: MTLO 0x1234_5678, then op 111 with P=0xFF.. -> lo=0x1234_5678, hi unchanged, ovf unchanged.
